randomizer_scheduler: RTL and testbench

Controller that owns one shared multi-channel randomizer instance. It seeds every channel after reset, then round-robin arbitrates per-channel noise requests. It drives the randomizer's channel/seed/init/ready inputs and captures its registered output. Each result is returned to the requester with a valid/ready handshake and the channel tag. Optional run-time reseed port for individual channels.

---
 rtl/randomizer_scheduler_pkg.sv | 23 ++
 rtl/randomizer_scheduler_rr_arbiter.sv | 39 +++
 rtl/randomizer_scheduler.sv | 149 ++++++++++++++
 tb/tb_randomizer_scheduler.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/randomizer_scheduler_pkg.sv
// Shared definitions for the randomizer scheduler: FSM state encodings and
// the channel-index width helper used by the top and the arbiter.
// No ports; pure package.
package randomizer_scheduler_pkg;

    localparam logic [2:0] S_SEED = 3'd0;
    localparam logic [2:0] S_IDLE = 3'd1;
    localparam logic [2:0] S_GEN  = 3'd2;
    localparam logic [2:0] S_CAP  = 3'd3;
    localparam logic [2:0] S_OUT  = 3'd4;

    // ceil(log2(n)) with a floor of 1 so a single-channel build still has a
    // one-bit channel field.
    function automatic int clog2_min1(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/randomizer_scheduler_rr_arbiter.sv
// Round-robin arbiter: picks the first set request at or after ptr, wrapping.
// Latency: purely combinational. Backpressure: none, caller decides when to use grant.
// Ports: req (per-channel requests), ptr (search start), grant (index), any_grant.
module randomizer_scheduler_rr_arbiter #(
    parameter int NR_CHANNELS   = 4,
    parameter int CHANNEL_WIDTH = 2
) (
    input  logic [NR_CHANNELS-1:0]   req,
    input  logic [CHANNEL_WIDTH-1:0] ptr,
    output logic [CHANNEL_WIDTH-1:0] grant,
    output logic                     any_grant
);

    localparam logic [CHANNEL_WIDTH:0] NR_CH_W = (CHANNEL_WIDTH + 1)'(NR_CHANNELS);

    logic [NR_CHANNELS-1:0]   rot;
    logic [CHANNEL_WIDTH-1:0] off;
    logic [CHANNEL_WIDTH:0]   sum;

    always_comb begin
        // Rotate so that bit 0 is the channel at ptr; the doubled vector makes
        // the wrap-around free.
        rot       = NR_CHANNELS'({req, req} >> ptr);
        off       = '0;
        any_grant = |req;
        // Walk downwards so the lowest set offset is the last one written.
        for (int i = NR_CHANNELS - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = CHANNEL_WIDTH'(i);
            end
        end
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= NR_CH_W) begin
            sum = sum - NR_CH_W;
        end
        grant = sum[CHANNEL_WIDTH-1:0];
    end

endmodule

// File: rtl/randomizer_scheduler.sv
// Owns one shared multi-channel randomizer: seeds every channel after reset,
// then round-robin serves per-channel noise requests, one word per 4 clk.
// Latency: request seen in idle -> out_valid 3 clk later. Backpressure: out_*
// held stable while !out_ready; no new randomizer step until the word is taken.
// Ports: clk/rst; req (per-channel level requests); out_data/out_ch/out_valid/
// out_ready (result handshake); reseed_valid/ch/value/ready (run-time reseed);
// seed_done (initial seeding finished); rndm_ch/seed/init/ready and rndm_out
// (randomizer control and its registered result).
module randomizer_scheduler
    import randomizer_scheduler_pkg::*;
#(
    parameter int  NR_CHANNELS   = 4,
    parameter int  OUTPUT_WIDTH  = 32,
    parameter int  SEED_BASE     = 1,
    localparam int CHANNEL_WIDTH = clog2_min1(NR_CHANNELS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NR_CHANNELS-1:0]   req,
    output logic [OUTPUT_WIDTH-1:0]  out_data,
    output logic [CHANNEL_WIDTH-1:0] out_ch,
    output logic                     out_valid,
    input  logic                     out_ready,
    input  logic                     reseed_valid,
    input  logic [CHANNEL_WIDTH-1:0] reseed_ch,
    input  logic [OUTPUT_WIDTH-1:0]  reseed_value,
    output logic                     reseed_ready,
    output logic                     seed_done,
    output logic [CHANNEL_WIDTH-1:0] rndm_ch,
    output logic [OUTPUT_WIDTH-1:0]  rndm_seed,
    output logic                     rndm_init,
    output logic                     rndm_ready,
    input  logic [OUTPUT_WIDTH-1:0]  rndm_out
);

    localparam logic [CHANNEL_WIDTH:0] NR_CH_W = (CHANNEL_WIDTH + 1)'(NR_CHANNELS);

    logic [2:0]               state;
    logic [CHANNEL_WIDTH:0]   seed_cnt;
    logic [CHANNEL_WIDTH-1:0] rr_ptr;
    logic [CHANNEL_WIDTH-1:0] grant;
    logic                     any_grant;
    logic [CHANNEL_WIDTH-1:0] ptr_nxt;
    logic [OUTPUT_WIDTH-1:0]  dflt_seed;
    logic                     reseed_in_range;

    randomizer_scheduler_rr_arbiter #(
        .NR_CHANNELS   (NR_CHANNELS),
        .CHANNEL_WIDTH (CHANNEL_WIDTH)
    ) u_arb (
        .req       (req),
        .ptr       (rr_ptr),
        .grant     (grant),
        .any_grant (any_grant)
    );

    // Default seed for the channel being initialised; an all-zero seed would
    // lock the LFSR, so it is bumped to 1.
    always_comb begin
        dflt_seed = OUTPUT_WIDTH'(SEED_BASE) + OUTPUT_WIDTH'(seed_cnt);
        if (dflt_seed == '0) begin
            dflt_seed = OUTPUT_WIDTH'(1);
        end
    end

    // Pointer moves to the channel after the winner; stays 0 for one channel.
    always_comb begin
        if (grant == CHANNEL_WIDTH'(NR_CHANNELS - 1)) begin
            ptr_nxt = '0;
        end else begin
            ptr_nxt = grant + 1'b1;
        end
    end

    assign reseed_in_range = ({1'b0, reseed_ch} < NR_CH_W);
    assign reseed_ready    = (state == S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_SEED;
            seed_cnt   <= '0;
            rr_ptr     <= '0;
            out_data   <= '0;
            out_ch     <= '0;
            out_valid  <= 1'b0;
            seed_done  <= 1'b0;
            rndm_ch    <= '0;
            rndm_seed  <= '0;
            rndm_init  <= 1'b0;
            rndm_ready <= 1'b0;
        end else begin
            case (state)
                S_SEED: begin
                    if (seed_cnt == NR_CH_W) begin
                        rndm_init <= 1'b0;
                        seed_done <= 1'b1;
                        state     <= S_IDLE;
                    end else begin
                        rndm_init <= 1'b1;
                        rndm_ch   <= seed_cnt[CHANNEL_WIDTH-1:0];
                        rndm_seed <= dflt_seed;
                        seed_cnt  <= seed_cnt + 1'b1;
                    end
                end
                S_IDLE: begin
                    rndm_init <= 1'b0;
                    // Reseed wins over requests; out-of-range channels are
                    // consumed without touching the randomizer.
                    if (reseed_valid) begin
                        if (reseed_in_range) begin
                            rndm_init <= 1'b1;
                            rndm_ch   <= reseed_ch;
                            rndm_seed <= reseed_value;
                        end
                    end else if (any_grant) begin
                        rndm_ch    <= grant;
                        rndm_ready <= 1'b1;
                        rr_ptr     <= ptr_nxt;
                        state      <= S_GEN;
                    end
                end
                S_GEN: begin
                    // Randomizer samples rndm_ready at this edge.
                    rndm_ready <= 1'b0;
                    state      <= S_CAP;
                end
                S_CAP: begin
                    out_data  <= rndm_out;
                    out_ch    <= rndm_ch;
                    out_valid <= 1'b1;
                    state     <= S_OUT;
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    rndm_init  <= 1'b0;
                    rndm_ready <= 1'b0;
                    out_valid  <= 1'b0;
                    state      <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_randomizer_scheduler.sv
// Directed bench for randomizer_scheduler with an attached 8-bit Galois LFSR
// randomizer (taps 0xB8). A second 5-channel instance covers out-of-range reseed.
module tb_randomizer_scheduler;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [7:0] out_data;
    logic [1:0] out_ch;
    logic       out_valid;
    logic       out_ready;
    logic       reseed_valid;
    logic [1:0] reseed_ch;
    logic [7:0] reseed_value;
    logic       reseed_ready;
    logic       seed_done;
    logic [1:0] rndm_ch;
    logic [7:0] rndm_seed;
    logic       rndm_init;
    logic       rndm_ready;
    logic [7:0] rndm_out;

    logic [4:0] req2;
    logic [7:0] out_data2;
    logic [2:0] out_ch2;
    logic       out_valid2;
    logic       out_ready2;
    logic       reseed_valid2;
    logic [2:0] reseed_ch2;
    logic [7:0] reseed_value2;
    logic       reseed_ready2;
    logic       seed_done2;
    logic [2:0] rndm_ch2;
    logic [7:0] rndm_seed2;
    logic       rndm_init2;
    logic       rndm_ready2;
    logic [7:0] rndm_out2;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int rdy_pulses = 0;
    int overlap_seen = 0;

    randomizer_scheduler #(.NR_CHANNELS(4), .OUTPUT_WIDTH(8), .SEED_BASE(1)) dut (
        .clk(clk), .rst(rst), .req(req),
        .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready),
        .reseed_valid(reseed_valid), .reseed_ch(reseed_ch), .reseed_value(reseed_value),
        .reseed_ready(reseed_ready), .seed_done(seed_done),
        .rndm_ch(rndm_ch), .rndm_seed(rndm_seed), .rndm_init(rndm_init),
        .rndm_ready(rndm_ready), .rndm_out(rndm_out)
    );

    randomizer_scheduler #(.NR_CHANNELS(5), .OUTPUT_WIDTH(8), .SEED_BASE(1)) dut5 (
        .clk(clk), .rst(rst), .req(req2),
        .out_data(out_data2), .out_ch(out_ch2), .out_valid(out_valid2), .out_ready(out_ready2),
        .reseed_valid(reseed_valid2), .reseed_ch(reseed_ch2), .reseed_value(reseed_value2),
        .reseed_ready(reseed_ready2), .seed_done(seed_done2),
        .rndm_ch(rndm_ch2), .rndm_seed(rndm_seed2), .rndm_init(rndm_init2),
        .rndm_ready(rndm_ready2), .rndm_out(rndm_out2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Attached randomizer: per-channel Galois LFSR, registered output.
    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return s[0] ? ((s >> 1) ^ 8'hB8) : (s >> 1);
    endfunction

    logic [7:0] lfsr [4];
    always @(posedge clk) begin
        if (rndm_init) begin
            lfsr[rndm_ch] <= (rndm_seed == 8'h00) ? 8'h01 : rndm_seed;
        end else if (rndm_ready) begin
            lfsr[rndm_ch] <= lfsr_next(lfsr[rndm_ch]);
            rndm_out      <= lfsr_next(lfsr[rndm_ch]);
        end
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rndm_ready) rdy_pulses <= rdy_pulses + 1;
        if (rndm_init && rndm_ready) overlap_seen <= overlap_seen + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Steps at least one negedge, then until out_valid or the budget runs out.
    task automatic wait_valid(output logic ok, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 30);
        ok = out_valid;
    endtask

    task automatic wait_seeded(input string tag);
        int n;
        n = 0;
        while (!seed_done && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {31'd0, seed_done}, 32'd1);
    endtask

    logic ok;
    int   n;
    int   prev;
    int   pulses0;
    logic [1:0] exp_ch  [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [7:0] exp_dat [5] = '{8'hB8, 8'h01, 8'hB9, 8'h02, 8'h5C};

    initial begin
        rst = 1'b1; req = '0; out_ready = 1'b0;
        reseed_valid = 1'b0; reseed_ch = '0; reseed_value = '0;
        req2 = '0; out_ready2 = 1'b0; reseed_valid2 = 1'b0; reseed_ch2 = '0;
        reseed_value2 = '0; rndm_out2 = '0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", {24'd0, out_data}, 32'd0);
        chk("rst_seed_done", {31'd0, seed_done}, 32'd0);
        chk("rst_rndm_init", {31'd0, rndm_init}, 32'd0);
        chk("rst_rndm_ready", {31'd0, rndm_ready}, 32'd0);
        chk("rst_reseed_ready", {31'd0, reseed_ready}, 32'd0);
        rst = 1'b0;

        // Seeding: channels 0..3 with seeds 1..4, then seed_done
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("seed_init", {31'd0, rndm_init}, 32'd1);
            chk("seed_ch", {30'd0, rndm_ch}, k);
            chk("seed_val", {24'd0, rndm_seed}, k + 1);
            chk("seed_not_done", {31'd0, seed_done}, 32'd0);
        end
        @(negedge clk);
        chk("seed_done", {31'd0, seed_done}, 32'd1);
        chk("seed_init_off", {31'd0, rndm_init}, 32'd0);
        chk("idle_reseed_ready", {31'd0, reseed_ready}, 32'd1);

        // Single request, dropped right after grant
        req = 4'b0001;
        @(negedge clk);
        req = 4'b0000;
        chk("single_gen_strobe", {31'd0, rndm_ready}, 32'd1);
        wait_valid(ok, n);
        chk("single_valid_seen", {31'd0, ok}, 32'd1);
        chk("single_latency", n + 1, 32'd3);
        chk("single_ch", {30'd0, out_ch}, 32'd0);
        chk("single_data", {24'd0, out_data}, 32'hB8);
        out_ready = 1'b1;
        @(negedge clk);
        chk("single_valid_drop", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b0;

        // Round robin from a fresh seeding
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wait_seeded("rr_seeded");
        req = 4'b1111;
        out_ready = 1'b1;
        prev = 0;
        for (int w = 0; w < 5; w++) begin
            wait_valid(ok, n);
            chk("rr_valid_seen", {31'd0, ok}, 32'd1);
            chk("rr_ch", {30'd0, out_ch}, {30'd0, exp_ch[w]});
            chk("rr_data", {24'd0, out_data}, {24'd0, exp_dat[w]});
            if (w > 0) chk("rr_period", cyc - prev, 32'd4);
            prev = cyc;
        end
        req = 4'b0000;
        @(negedge clk);
        out_ready = 1'b0;
        chk("rr_idle_valid", {31'd0, out_valid}, 32'd0);

        // Backpressure on channel 1 (state 0x01 -> 0xB8)
        pulses0 = rdy_pulses;
        req = 4'b0010;
        wait_valid(ok, n);
        chk("bp_valid_seen", {31'd0, ok}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_hold_data", {24'd0, out_data}, 32'hB8);
        end
        chk("bp_hold_ch", {30'd0, out_ch}, 32'd1);
        chk("bp_single_gen", rdy_pulses - pulses0, 32'd1);
        out_ready = 1'b1;
        req = 4'b0000;
        @(negedge clk);
        chk("bp_release", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b0;

        // Reseed ch2 to 1 alongside a ch2 request; 5-ch instance drops ch 5
        reseed_valid = 1'b1; reseed_ch = 2'd2; reseed_value = 8'h01; req = 4'b0100;
        reseed_valid2 = 1'b1; reseed_ch2 = 3'd5; reseed_value2 = 8'h33;
        #1;
        chk("rs_ready", {31'd0, reseed_ready}, 32'd1);
        chk("rs5_ready", {31'd0, reseed_ready2}, 32'd1);
        @(negedge clk);
        reseed_valid = 1'b0; reseed_valid2 = 1'b0;
        chk("rs_init", {31'd0, rndm_init}, 32'd1);
        chk("rs_ch", {30'd0, rndm_ch}, 32'd2);
        chk("rs_seed", {24'd0, rndm_seed}, 32'h01);
        chk("rs_no_gen", {31'd0, rndm_ready}, 32'd0);
        chk("rs5_dropped", {31'd0, rndm_init2}, 32'd0);
        wait_valid(ok, n);
        chk("rs_valid_seen", {31'd0, ok}, 32'd1);
        chk("rs_out_ch", {30'd0, out_ch}, 32'd2);
        chk("rs_out_data", {24'd0, out_data}, 32'hB8);
        out_ready = 1'b1;
        req = 4'b0000;
        @(negedge clk);
        out_ready = 1'b0;

        // Zero seed passes through; in-range ch 4 on the 5-channel instance
        reseed_valid = 1'b1; reseed_ch = 2'd3; reseed_value = 8'h00;
        reseed_valid2 = 1'b1; reseed_ch2 = 3'd4; reseed_value2 = 8'h33;
        @(negedge clk);
        reseed_valid = 1'b0; reseed_valid2 = 1'b0;
        chk("rs0_init", {31'd0, rndm_init}, 32'd1);
        chk("rs0_ch", {30'd0, rndm_ch}, 32'd3);
        chk("rs0_seed", {24'd0, rndm_seed}, 32'h00);
        chk("rs5_ch4_init", {31'd0, rndm_init2}, 32'd1);
        chk("rs5_ch4_ch", {29'd0, rndm_ch2}, 32'd4);
        chk("rs5_ch4_seed", {24'd0, rndm_seed2}, 32'h33);
        @(negedge clk);

        // Reset while in the capture state
        req = 4'b0001;
        @(negedge clk);
        chk("mid_gen", {31'd0, rndm_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        req = 4'b0000;
        @(negedge clk);
        chk("mid_valid_clr", {31'd0, out_valid}, 32'd0);
        chk("mid_seed_done_clr", {31'd0, seed_done}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_reseed_init", {31'd0, rndm_init}, 32'd1);
        chk("mid_reseed_ch", {30'd0, rndm_ch}, 32'd0);
        chk("mid_reseed_val", {24'd0, rndm_seed}, 32'h01);
        wait_seeded("mid_seeded");
        req = 4'b0001;
        wait_valid(ok, n);
        req = 4'b0000;
        chk("mid_valid_seen", {31'd0, ok}, 32'd1);
        chk("mid_out_ch", {30'd0, out_ch}, 32'd0);
        chk("mid_out_data", {24'd0, out_data}, 32'hB8);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        chk("init_ready_overlap", overlap_seen, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
